// File: rtl/rv_pkg.sv
// Shared core definitions: data width, canonical NOP encoding and
// the default reset vector used by the fetch front end.
package rv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Width of the stale-response drop counter; wide enough for many
    // back-to-back redirects with a deep memory pipeline.
    localparam int DROP_W = 16;

    // Force an address onto a 4-byte instruction boundary.
    function automatic logic [XLEN-1:0] word_align(
        input logic [XLEN-1:0] a
    );
        return a & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction buffer: slots are reserved at request time,
// filled in order as responses return, and popped in order by decode.
module fetch_queue
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   reserve_i,
    input  logic [XLEN-1:0]        res_addr_i,
    input  logic                   fill_i,
    input  logic [XLEN-1:0]        fill_data_i,
    input  logic                   pop_i,
    output logic                   can_reserve_o,
    output logic                   head_valid_o,
    output logic [XLEN-1:0]        head_addr_o,
    output logic [XLEN-1:0]        head_data_o,
    output logic [$clog2(DEPTH):0] pending_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   fptr_q, fptr_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   rcnt_q, rcnt_d;
    logic [CW-1:0]   ucnt_q, ucnt_d;
    logic [DEPTH-1:0] rsv_q, rsv_d;
    logic [DEPTH-1:0] fil_q, fil_d;

    logic [XLEN-1:0] addr_q [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];

    logic rsv_ok;
    logic fill_ok;
    logic pop_ok;

    // Occupancy uses registered counts only, so a slot popped this
    // cycle is not offered for reservation until the next one.
    assign can_reserve_o = (rcnt_q < CW'(DEPTH));
    assign head_valid_o  = rsv_q[head_q] & fil_q[head_q];
    assign head_addr_o   = addr_q[head_q];
    assign head_data_o   = data_q[head_q];
    assign pending_o     = ucnt_q;

    assign rsv_ok  = reserve_i & can_reserve_o;
    assign fill_ok = fill_i & (ucnt_q != '0);
    assign pop_ok  = pop_i & head_valid_o;

    // Pointer, flag and count updates; a flush empties every slot.
    always_comb begin
        head_d = head_q;
        fptr_d = fptr_q;
        tail_d = tail_q;
        rcnt_d = rcnt_q;
        ucnt_d = ucnt_q;
        rsv_d  = rsv_q;
        fil_d  = fil_q;
        if (flush_i) begin
            head_d = '0;
            fptr_d = '0;
            tail_d = '0;
            rcnt_d = '0;
            ucnt_d = '0;
            rsv_d  = '0;
            fil_d  = '0;
        end else begin
            if (rsv_ok) begin
                rsv_d[tail_q] = 1'b1;
                fil_d[tail_q] = 1'b0;
                tail_d = tail_q + 1'b1;
            end
            if (fill_ok) begin
                fil_d[fptr_q] = 1'b1;
                fptr_d = fptr_q + 1'b1;
            end
            if (pop_ok) begin
                rsv_d[head_q] = 1'b0;
                fil_d[head_q] = 1'b0;
                head_d = head_q + 1'b1;
            end
            rcnt_d = rcnt_q + CW'(rsv_ok) - CW'(pop_ok);
            ucnt_d = ucnt_q + CW'(rsv_ok) - CW'(fill_ok);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            fptr_q <= '0;
            tail_q <= '0;
            rcnt_q <= '0;
            ucnt_q <= '0;
            rsv_q  <= '0;
            fil_q  <= '0;
        end else begin
            head_q <= head_d;
            fptr_q <= fptr_d;
            tail_q <= tail_d;
            rcnt_q <= rcnt_d;
            ucnt_q <= ucnt_d;
            rsv_q  <= rsv_d;
            fil_q  <= fil_d;
        end
    end

    // Slot payload storage; validity is tracked by the flags above.
    always_ff @(posedge clk) begin
        if (rsv_ok) begin
            addr_q[tail_q] <= res_addr_i;
        end
        if (fill_ok) begin
            data_q[fptr_q] <= fill_data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC, credit-limited memory
// requests, in-order response queue and stale-response dropping.
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int              QUEUE_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int AW = $clog2(QUEUE_DEPTH);

    logic [XLEN-1:0]   pc_q, pc_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [DROP_W-1:0] drop_base;
    logic [DROP_W-1:0] live;

    logic            can_rsv;
    logic            req_fire;
    logic            dropping;
    logic            fill;
    logic            pop;
    logic            head_vld;
    logic [AW:0]     pending;
    logic [XLEN-1:0] head_addr;
    logic [XLEN-1:0] head_data;

    assign dropping       = (drop_q != '0);
    assign imem_req_valid = rst_n & can_rsv & ~redirect_valid;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign fill           = imem_resp_valid & ~redirect_valid & ~dropping;
    assign pop            = head_vld & inst_ready & ~redirect_valid;

    assign inst_valid = head_vld;
    assign inst_data  = head_vld ? head_data : INST_NOP;
    assign inst_pc    = head_vld ? head_addr : RESET_PC;

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (redirect_valid),
        .reserve_i     (req_fire),
        .res_addr_i    (pc_q),
        .fill_i        (fill),
        .fill_data_i   (imem_resp_data),
        .pop_i         (pop),
        .can_reserve_o (can_rsv),
        .head_valid_o  (head_vld),
        .head_addr_o   (head_addr),
        .head_data_o   (head_data),
        .pending_o     (pending)
    );

    // Next fetch address: a redirect target wins over sequential advance.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = word_align(redirect_pc);
        end else if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // A response either retires one pending drop or one live request;
    // on redirect the surviving live requests join the drop count.
    always_comb begin
        drop_base = drop_q;
        live      = DROP_W'(pending);
        if (imem_resp_valid) begin
            if (dropping) begin
                drop_base = drop_q - DROP_W'(1);
            end else if (live != '0) begin
                live = live - DROP_W'(1);
            end
        end
        drop_d = redirect_valid ? drop_base + live : drop_base;
    end

    // PC and drop counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit with a transaction-level model of
// the expected fetch stream and an in-order variable-latency memory.
module tb_fetch_unit;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC    (RST_PC),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Model state.
    logic [31:0] exp_req_pc;
    logic [31:0] exp_inst_pc;
    int          live;
    int          now = 0;
    int          last_due = 0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          delivered = 0;
    int          reqs = 0;
    bit          prev_redir = 0;
    bit          prev_hold = 0;

    // Stimulus knobs.
    int          lat_min = 1;
    int          lat_max = 1;
    int          p_redir = 0;
    int          p_ready = 100;
    int          p_mready = 100;
    bit          force_redir = 0;
    logic [31:0] force_pc = '0;

    // Directed probes.
    bit          redir_arm = 0;
    bit          first_arm = 0;
    bit          req_arm = 0;
    logic [31:0] first_pc = '1;
    logic [31:0] first_req = '1;
    bit          wrap_arm = 0;
    bit          saw_wrap = 0;

    // Last sampled outputs.
    logic        s_req_v;
    logic [31:0] s_req_a;
    logic        s_inst_v;
    logic [31:0] s_inst_pc;
    logic [31:0] s_inst_d;

    task automatic model_reset();
        exp_req_pc  = RST_PC;
        exp_inst_pc = RST_PC;
        live = 0;
        mq_addr.delete();
        mq_due.delete();
        last_due = now;
        prev_redir = 0;
        prev_hold = 0;
    endtask

    task automatic idle_inputs();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        inst_ready      = 1'b0;
    endtask

    // Enter at a falling edge; leave at the next falling edge.
    task automatic cycle();
        logic        rv, rdy, mrdy, resp;
        logic [31:0] rpc;
        int          due;
        rv = force_redir || (int'($urandom_range(99)) < p_redir);
        if (force_redir) rpc = force_pc;
        else if ($urandom_range(9) == 0) rpc = 32'hFFFF_FFF0 | $urandom_range(15);
        else rpc = $urandom();
        force_redir = 0;
        rdy  = int'($urandom_range(99)) < p_ready;
        mrdy = int'($urandom_range(99)) < p_mready;
        resp = (mq_due.size() > 0) && (mq_due[0] <= now);
        redirect_valid  = rv;
        redirect_pc     = rpc;
        inst_ready      = rdy;
        imem_req_ready  = mrdy;
        imem_resp_valid = resp;
        imem_resp_data  = resp ? memfn(mq_addr[0]) : $urandom();
        #1;
        s_req_v   = imem_req_valid;
        s_req_a   = imem_req_addr;
        s_inst_v  = inst_valid;
        s_inst_pc = inst_pc;
        s_inst_d  = inst_data;
        chk("req_valid", 32'(s_req_v), 32'((live < DEPTH) && !rv));
        if (s_req_v) chk("req_addr", s_req_a, exp_req_pc);
        if (prev_redir) chk("flush_valid", 32'(s_inst_v), 32'(0));
        if (prev_hold) chk("hold_valid", 32'(s_inst_v), 32'(1));
        if (s_inst_v) begin
            chk("inst_pc", s_inst_pc, exp_inst_pc);
            chk("inst_data", s_inst_d, memfn(exp_inst_pc));
        end
        @(posedge clk);
        if (s_req_v && mrdy) begin
            due = now + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq_addr.push_back(s_req_a);
            mq_due.push_back(due);
            if (req_arm) begin
                first_req = s_req_a;
                req_arm = 0;
            end
            if (wrap_arm && s_req_a == 32'h0) saw_wrap = 1;
            exp_req_pc = exp_req_pc + 32'd4;
            live++;
            reqs++;
        end
        if (resp) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (s_inst_v && rdy && !rv) begin
            if (first_arm) begin
                first_pc = s_inst_pc;
                first_arm = 0;
            end
            exp_inst_pc = exp_inst_pc + 32'd4;
            live--;
            delivered++;
        end
        if (rv) begin
            exp_req_pc  = rpc & ~32'h3;
            exp_inst_pc = rpc & ~32'h3;
            live = 0;
            if (redir_arm) begin
                first_arm = 1;
                req_arm = 1;
                redir_arm = 0;
            end
        end
        prev_redir = rv;
        prev_hold  = s_inst_v && !rdy && !rv;
        now++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'(0));
        chk("rst_inst_valid", 32'(inst_valid), 32'(0));
        chk("rst_inst_data", inst_data, NOP);
        chk("rst_inst_pc", inst_pc, RST_PC);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic knobs(input int lmin, input int lmax, input int pr,
                         input int prd, input int pm);
        lat_min = lmin;
        lat_max = lmax;
        p_redir = pr;
        p_ready = prd;
        p_mready = pm;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int r0;
        int d0;
        @(negedge clk);

        // Streaming from reset: one instruction per cycle from cycle 2.
        knobs(1, 1, 0, 100, 100);
        do_reset();
        for (int c = 0; c < 12; c++) begin
            cycle();
            chk("lat_valid", 32'(s_inst_v), 32'(c >= 2));
        end

        // Decode stalled: queue fills with four requests then stops.
        do_reset();
        knobs(1, 1, 0, 0, 100);
        r0 = reqs;
        repeat (10) cycle();
        chk("stall_reqs", 32'(reqs - r0), 32'(4));
        chk("stall_req_valid", 32'(s_req_v), 32'(0));
        chk("stall_pc", s_inst_pc, 32'h0);
        knobs(1, 1, 0, 100, 100);
        repeat (6) cycle();

        // Redirect with responses outstanding.
        knobs(2, 2, 0, 100, 100);
        do_reset();
        for (int i = 0; i < 20 && mq_addr.size() != 2; i++) cycle();
        chk("outstanding2", 32'(mq_addr.size()), 32'(2));
        force_redir = 1;
        force_pc = 32'h0000_0103;
        redir_arm = 1;
        repeat (12) cycle();
        chk("redir_req", first_req, 32'h0000_0100);
        chk("redir_inst", first_pc, 32'h0000_0100);

        // Response coincident with redirect, then a second redirect.
        knobs(3, 3, 0, 100, 100);
        do_reset();
        repeat (6) cycle();
        for (int i = 0; i < 10; i++) begin
            if (mq_due.size() > 0 && mq_due[0] <= now) break;
            cycle();
        end
        force_redir = 1;
        force_pc = 32'h0000_2000;
        cycle();
        force_redir = 1;
        force_pc = 32'h0000_3002;
        redir_arm = 1;
        repeat (15) cycle();
        chk("redir2_inst", first_pc, 32'h0000_3000);

        // Address wrap at the top of the address space.
        knobs(1, 1, 0, 100, 100);
        force_redir = 1;
        force_pc = 32'hFFFF_FFF8;
        wrap_arm = 1;
        saw_wrap = 0;
        repeat (8) cycle();
        wrap_arm = 0;
        chk("pc_wrap", 32'(saw_wrap), 32'(1));

        // Asynchronous reset in the middle of a stream.
        repeat (6) cycle();
        chk("pre_rst_valid", 32'(s_inst_v), 32'(1));
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_req_valid", 32'(imem_req_valid), 32'(0));
        chk("async_inst_valid", 32'(inst_valid), 32'(0));
        chk("async_inst_data", inst_data, NOP);
        chk("async_inst_pc", inst_pc, RST_PC);
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle();
        chk("restart_req", s_req_a, RST_PC);
        repeat (8) cycle();

        // Long randomized run.
        do_reset();
        knobs(1, 4, 4, 70, 75);
        d0 = delivered;
        repeat (3000) cycle();
        chk("progress", 32'((delivered - d0) > 200), 32'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter QUEUE_DEPTH, default 4, instruction queue slots; power of two, at least 2.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 imem_req_valid  out  1  fetch request valid.
REQ-006 imem_req_ready  in  1  memory accepts request.
REQ-007 imem_req_addr  out  32  word-aligned fetch address.
REQ-008 imem_resp_valid  in  1  response valid, in request order, never back-pressured.
REQ-009 imem_resp_data  in  32  fetched instruction word.
REQ-010 redirect_valid  in  1  branch/jump/trap redirect, single-cycle pulse.
REQ-011 redirect_pc  in  32  redirect target.
REQ-012 inst_valid  out  1  instruction available to decode/immediate stage.
REQ-013 inst_ready  in  1  decode consumes instruction.
REQ-014 inst_data  out  32  instruction word.
REQ-015 inst_pc  out  32  address of inst_data.

Function
REQ-016 Request handshake SHALL complete when imem_req_valid and imem_req_ready are both high on a rising edge; output handshake likewise on inst_valid and inst_ready.
REQ-017 imem_req_valid SHALL be high iff reserved slots < QUEUE_DEPTH and redirect_valid is low; imem_req_addr SHALL equal current PC.
REQ-018 Each request handshake SHALL reserve the tail slot, record imem_req_addr in it and advance PC by 4, wrapping modulo 2^32.
REQ-019 A slot freed by a dequeue SHALL become reservable the following cycle; no same-cycle credit bypass.
REQ-020 Each non-dropped imem_resp_valid SHALL fill the oldest reserved-unfilled slot with imem_resp_data at that edge.
REQ-021 inst_valid SHALL be high iff the head slot is reserved and filled; inst_data/inst_pc SHALL come from the head slot, stable while inst_valid is high and inst_ready is low.
REQ-022 Minimum latency SHALL be 2 cycles from request handshake to inst_valid when the response arrives 1 cycle after the handshake.
REQ-023 With memory latency 1 and inst_ready held high, QUEUE_DEPTH 4 SHALL sustain one instruction per cycle after the first 2 cycles.
REQ-024 On redirect_valid: PC SHALL load {redirect_pc[31:2],2'b00}; all slots SHALL be freed; inst_valid SHALL be low the next cycle.
REQ-025 On redirect_valid: drop counter SHALL load the number of requests handshaken but not yet responded, excluding any response arriving in that same cycle.
REQ-026 A response arriving the same cycle as redirect_valid SHALL be discarded.
REQ-027 While the drop counter is non-zero, each imem_resp_valid SHALL be discarded and the counter decremented; the counter never underflows.
REQ-028 A second redirect while the drop counter is non-zero SHALL add the current outstanding requests to the remaining drop count.
REQ-029 A request SHALL be issued in the cycle after a redirect, at the new PC, independent of the drop counter.
REQ-030 Output dequeue in a redirect cycle SHALL be ignored; that instruction is flushed.

Reset
REQ-031 While rst_n is low: PC = RESET_PC; queue empty; drop counter 0; imem_req_valid = 0; inst_valid = 0; inst_data = 32'h0000_0013 (NOP); inst_pc = RESET_PC.
REQ-032 The first request SHALL assert in the first cycle after rst_n deasserts.
REQ-033 Reset asserted mid-operation SHALL discard all slots and outstanding state immediately; responses arriving after reset for pre-reset requests are outside the contract.

Structure
REQ-034 Shared package rv_pkg SHALL hold XLEN=32, INST_NOP=32'h0000_0013, and the default RESET_PC.
REQ-035 Sub-module fetch_queue SHALL implement the circular buffer with reserve/fill/pop pointers, per-slot reserved/filled flags and wrap-around pointers.

Verification
REQ-036 Reset release, RESET_PC=0, memory latency 1, inst_ready=1 -> imem_req_addr 0,4,8,...; inst_pc 0,4,8 in order from cycle 2, one instruction per cycle.
REQ-037 inst_ready=0 for 10 cycles -> exactly 4 requests issued, imem_req_valid low afterwards; inst_pc stays 0x0 and inst_data stays stable.
REQ-038 Redirect to 0x0000_0103 with 2 responses outstanding -> next request to 0x100, the 2 stale responses are dropped, and the first inst_pc is 0x100.
REQ-039 Response coincident with redirect, then a second redirect while dropping -> no stale instruction appears and the drop count totals correctly.
REQ-040 PC 0xFFFF_FFFC fetch -> next imem_req_addr 0x0000_0000.
REQ-041 rst_n pulsed low mid-stream, asynchronously -> inst_valid and imem_req_valid drop immediately, then fetch restarts at RESET_PC.
